crc_engine: RTL



---
 rtl/crc_pkg.sv | 29 ++
 rtl/crc_byte_step.sv | 40 ++++
 rtl/crc_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// crc_pkg: shared constants, FSM state type and helpers for the CRC-32 engine.
//   CRC32_POLY         normal (MSB-first) form of the IEEE 802.3 polynomial
//   CRC32_INIT         register seed at the start of every frame
//   CRC32_XOROUT       final inversion applied to form the published CRC
//   CRC32_RESIDUE_REFL raw register left behind by a good frame plus its FCS
//                      when the register runs in reflected (LSB-first) mode
//   crc_state_t        frame FSM states
//   bitrev32           bit-order reversal, used to get the right-shifting poly
package crc_pkg;

  localparam logic [31:0] CRC32_POLY         = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_REFL = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1
  } crc_state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] value);
    logic [31:0] result;
    for (int i = 0; i < 32; i++) begin
      result[i] = value[31-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step: purely combinational fold of one byte into a CRC-32 register.
//   crc_in   : register value before the byte
//   data     : byte to fold
//   crc_next : register value after the byte
// POLY is given in normal form; in reflected mode it is bit-reversed here at
// elaboration and the register shifts right, consuming the byte LSB first.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY    = CRC32_POLY,
  parameter bit          REFLECT = 1'b1
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] STEP_POLY = REFLECT ? bitrev32(POLY) : POLY;

  logic [31:0] work;

  always_comb begin
    work = crc_in;
    if (REFLECT) begin
      // Byte enters at the low end; each shift drops bit 0 as feedback.
      work = work ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
        work = work[0] ? ((work >> 1) ^ STEP_POLY) : (work >> 1);
      end
    end else begin
      // Byte enters at the high end; each shift drops bit 31 as feedback.
      work = work ^ {data, 24'h000000};
      for (int i = 0; i < 8; i++) begin
        work = work[31] ? ((work << 1) ^ STEP_POLY) : (work << 1);
      end
    end
    crc_next = work;
  end

endmodule

// File: rtl/crc_engine.sv
// crc_engine: CRC-32 generator/checker, DATA_BYTES byte lanes per beat.
//   clk, rst    : clock and synchronous active-high reset
//   start       : first beat of a frame (qualified by data_valid)
//   data_in     : beat data, lane 0 = bits [7:0] = earliest byte
//   data_valid  : beat present
//   data_last   : final beat of a frame (qualified by data_valid)
//   data_keep   : per-lane enables, only honoured on the last beat
//   crc_out     : register ^ XOR_OUT of the last completed frame (held)
//   crc_valid   : one-cycle pulse when crc_out/crc_match are updated
//   crc_match   : raw register equalled RESIDUE at the end of the frame
//   busy        : a frame is in progress
module crc_engine
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES = 1,
  parameter logic [31:0] POLY       = CRC32_POLY,
  parameter logic [31:0] INIT       = CRC32_INIT,
  parameter logic [31:0] XOR_OUT    = CRC32_XOROUT,
  parameter bit          REFLECT    = 1'b1,
  parameter logic [31:0] RESIDUE    = CRC32_RESIDUE_REFL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    data_last,
  input  logic [DATA_BYTES-1:0]   data_keep,
  output logic [31:0]             crc_out,
  output logic                    crc_valid,
  output logic                    crc_match,
  output logic                    busy
);

  crc_state_t  state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [31:0] crc_out_reg, crc_out_next;
  logic        valid_reg, valid_next;
  logic        match_reg, match_next;
  logic        fold;

  // lane_crc[i] is the register before lane i; lane_crc[DATA_BYTES] is the
  // register after the whole beat.
  logic [31:0]           lane_crc [0:DATA_BYTES];
  logic [31:0]           step_crc [0:DATA_BYTES-1];
  logic [DATA_BYTES-1:0] lane_en;

  // A start beat always reseeds, which also covers abandoning a frame in ACCUM.
  assign lane_crc[0] = start ? INIT : crc_reg;

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      crc_byte_step #(
        .POLY    (POLY),
        .REFLECT (REFLECT)
      ) u_step (
        .crc_in   (lane_crc[gi]),
        .data     (data_in[8*gi +: 8]),
        .crc_next (step_crc[gi])
      );

      // Disabled lanes pass the register through untouched, so kept lanes
      // are folded in ascending order even when the keep mask has holes.
      assign lane_en[gi]      = data_last ? data_keep[gi] : 1'b1;
      assign lane_crc[gi + 1] = lane_en[gi] ? step_crc[gi] : lane_crc[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    crc_out_next = crc_out_reg;
    match_next   = match_reg;
    valid_next   = 1'b0;
    fold         = 1'b0;

    case (state_reg)
      IDLE:    fold = data_valid && start;
      ACCUM:   fold = data_valid;
      default: state_next = IDLE;
    endcase

    if (fold) begin
      if (data_last) begin
        // Reload the seed now so a new frame may start on the next cycle.
        state_next   = IDLE;
        crc_next     = INIT;
        crc_out_next = lane_crc[DATA_BYTES] ^ XOR_OUT;
        match_next   = (lane_crc[DATA_BYTES] == RESIDUE);
        valid_next   = 1'b1;
      end else begin
        state_next = ACCUM;
        crc_next   = lane_crc[DATA_BYTES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      crc_reg     <= INIT;
      crc_out_reg <= 32'h00000000;
      valid_reg   <= 1'b0;
      match_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      crc_out_reg <= crc_out_next;
      valid_reg   <= valid_next;
      match_reg   <= match_next;
    end
  end

  assign crc_out   = crc_out_reg;
  assign crc_valid = valid_reg;
  assign crc_match = match_reg;
  assign busy      = (state_reg == ACCUM);

endmodule
